// File: rtl/pll_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// All timing is counted in cycles of the free-running 20 MHz reference clock.
package pll_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } sup_state_t;

  localparam int unsigned REF_CLK_HZ         = 20_000_000;
  localparam int unsigned DEF_PLL_RST_CYCLES = 32;
  // 10 ms expressed in reference-clock cycles.
  localparam int unsigned DEF_LOCK_TIMEOUT   = REF_CLK_HZ / 100;
  localparam int unsigned DEF_SETTLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  // Largest of the three timed intervals; sizes the shared cycle counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset to 0.
// Also used for bridging resets into the CLKOP domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops in the destination domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make meta and q sample together, so
      // the flop order in the source does not matter.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies LOCK for a stable
// settle period before releasing downstream reset, retries on lock timeout
// and parks in FAULT after too many retries. Runs on the reference clock so
// it keeps working while the PLL output is absent.
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W          =
    $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       fault,
  output logic [1:0] retries,
  output logic [7:0] loss_count
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  sup_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       retries_d;
  logic [7:0]       loss_d;
  logic             lock_s;
  logic             pll_rst_d, sys_rst_d, fault_d;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // State register plus registered outputs, all updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PLL_RESET;
      cnt        <= '0;
      retries    <= '0;
      loss_count <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      retries    <= retries_d;
      loss_count <= loss_d;
      pll_rst    <= pll_rst_d;
      sys_rst    <= sys_rst_d;
      fault      <= fault_d;
    end
  end

  // Next-state, counter and status bookkeeping; restart overrides everything.
  always_comb begin
    // NOTE: every target gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d   = state;
    cnt_d     = cnt;
    retries_d = retries;
    loss_d    = loss_count;

    if (restart) begin
      state_d   = PLL_RESET;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          // Lock takes precedence over a timeout on the same cycle.
          if (lock_s) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retries == RETRY_LIMIT) begin
              state_d = FAULT;
            end else begin
              state_d   = PLL_RESET;
              retries_d = retries + 2'd1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end

        SETTLE: begin
          // Any drop restarts qualification with a fresh timeout window.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_d   = RUN;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
            loss_d  = (loss_count == 8'hFF) ? loss_count : loss_count + 8'd1;
          end
        end

        FAULT: begin
          // Parked until restart or rst.
        end

        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output values derived from the state being entered.
  always_comb begin
    pll_rst_d = (state_d == PLL_RESET) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    fault_d   = (state_d == FAULT);
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the board PLL (20 MHz ref in, 3.33333 MHz CLKOP out) and gates downstream reset on a stable lock.
- Runs on the free-running 20 MHz reference clock, so it keeps operating while CLKOP is absent.
- Drives the PLL RST pin, synchronises and qualifies LOCK, and retries on lock timeout.
- Releases sys_rst only after lock has been stable for a programmable time; re-asserts it on loss of lock.

Parameters:
- PLL_RST_CYCLES, 32: cycles pll_rst is held high per reset attempt (>=2).
- LOCK_TIMEOUT, 200000: cycles allowed in WAIT_LOCK before a retry (10 ms at 20 MHz).
- SETTLE_CYCLES, 1024: consecutive cycles lock must stay high before sys_rst releases (>=1).
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- CNT_W, $clog2(max of the three counts)+1: shared cycle-counter width.

Ports:
- clk  in  1  20 MHz reference clock (same net as PLL CLKI).
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  raw PLL LOCK; asynchronous to clk.
- restart  in  1  clk-domain single-cycle pulse; forces a new PLL reset sequence from any state.
- pll_rst  out  1  to PLL RST; high = PLL held in reset.
- sys_rst  out  1  active-high reset for downstream logic, clk domain.
- fault  out  1  high while in FAULT.
- retries  out  2  timeouts in the current attempt sequence.
- loss_count  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Input sync: locked passes through a 2-flop synchroniser to lock_s. All decisions use lock_s only.
- Outputs: all outputs are registered, computed from the next state, and change on the same edge as the state register. No combinational output paths.
- Reset values (async): state=PLL_RESET, cnt=0, pll_rst=1, sys_rst=1, fault=0, retries=0, loss_count=0, sync flops=0.
- Output map:
  - pll_rst=1 in PLL_RESET and FAULT.
  - sys_rst=0 only in RUN.
  - fault=1 only in FAULT.
- PLL_RESET:
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK:
  - If lock_s: go to SETTLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 and retries==MAX_RETRIES: go to FAULT.
  - Else if cnt==LOCK_TIMEOUT-1: retries+1, go to PLL_RESET, cnt=0.
  - Else cnt++.
  - If lock_s and timeout coincide, lock wins.
- SETTLE:
  - If !lock_s: go to WAIT_LOCK, cnt=0. The timeout restarts; retries is unchanged.
  - Else if cnt==SETTLE_CYCLES-1: go to RUN, retries=0.
  - Else cnt++.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles with lock_s high.
- RUN:
  - If !lock_s: go to PLL_RESET, cnt=0, loss_count+1 (saturates at 255).
  - sys_rst rises on that same edge.
- FAULT:
  - Holds until rst or restart.
  - restart: go to PLL_RESET, cnt=0, retries=0.
- restart has highest priority in every state: go to PLL_RESET, cnt=0, retries=0, loss_count unchanged.
- Latency:
  - locked rise: sys_rst falls 3+SETTLE_CYCLES edges after the first edge that samples locked high.
  - locked fall in RUN: sys_rst rises 3 edges after the first edge that samples locked low.
- Glitches: a lock_s drop of any length (≥1 cycle) during SETTLE restarts qualification. Lock glitches during PLL_RESET are ignored.
- Reset mid-operation: asserting rst in any state forces the reset values immediately, and the full sequence restarts on release.
- Counter: a single CNT_W-bit counter is shared by all timed states and cleared on every state change.

Decomposition:
- Shared package pll_pkg holds:
  - enum sup_state_t {PLL_RESET, WAIT_LOCK, SETTLE, RUN, FAULT};
  - default timing constants: 20 MHz ref, 10 ms timeout, settle count.
- Sub-module sync2: a 2-flop synchroniser with async active-high reset to 0. Reused later for CLKOP-domain reset bridging.

Test Plan (bench uses PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2):
- Clean start: release rst, raise locked at cycle 10 -> pll_rst low after 4 cycles; sys_rst falls 11 edges after locked sampled high; retries=0, fault=0.
- Glitch in settle: locked high, low for 1 cycle at settle count 5, high again -> sys_rst stays high; a full 8-cycle settle restarts after returning through WAIT_LOCK.
- Timeouts to fault: locked held low -> three pll_rst pulses of 4 cycles each; retries goes 0→1→2; after the third 20-cycle timeout fault=1 and pll_rst=1 held; restart pulse -> PLL_RESET, retries=0.
- Loss in RUN: reach RUN, drop locked -> sys_rst=1 three edges later, pll_rst pulses 4 cycles, loss_count=1; relock -> RUN again. Force 300 losses -> loss_count=255.
- Simultaneous events: lock_s rises on the WAIT_LOCK timeout cycle -> SETTLE entered and retries unchanged. Restart during SETTLE -> PLL_RESET.
- Async reset mid-RUN: assert rst between clock edges -> sys_rst=1 and pll_rst=1 without waiting for a clock edge; all counters read 0.
